seg_scan_hc595: RTL and testbench

- Downstream consumer of the 8-digit BCD converter output (bit_0..bit_7).
- Time-multiplexes the eight digits onto an 8-digit common-anode 7-segment display.
- Drives the display through two daisy-chained 74HC595 shift registers.
- Per digit: decodes BCD to segment code, shifts a 16-bit frame serially, pulses the storage clock, then holds the frame for one scan slot.

---
 rtl/seg_scan_hc595.sv | 126 ++++++++++++
 tb/tb_seg_scan_hc595.sv | 127 ++++++++++++
 2 files changed

// File: rtl/seg_scan_hc595.sv
// seg_scan_hc595: scans eight BCD digits onto a common-anode 7-segment display through two chained 74HC595s (optional LEADING_ZERO_BLANK_EN blanks leading zeros).
module seg_scan_hc595 #(
    parameter int SCAN_CNT_MAX = 50000,
    parameter int SHIFT_DIV    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bit_0,
    input  logic [3:0] bit_1,
    input  logic [3:0] bit_2,
    input  logic [3:0] bit_3,
    input  logic [3:0] bit_4,
    input  logic [3:0] bit_5,
    input  logic [3:0] bit_6,
    input  logic [3:0] bit_7,
    output logic       ds,
    output logic       shcp,
    output logic       stcp,
    output logic       oe_n
);
    localparam int CW = $clog2(SCAN_CNT_MAX);
    localparam int PW = $clog2(SHIFT_DIV);

    typedef enum logic [1:0] {WAIT, LOAD, SHIFT, LATCH} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   scan_cnt;
    logic [2:0]      idx;
    logic [PW-1:0]   phase;
    logic [3:0]      bit_cnt;
    logic [31:0]     snap, live, src;
    logic [15:0]     frame, frame_nx;
    logic [3:0]      digit;
    logic [7:0]      seg;
    logic            last_phase;

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 8'hC0;
            4'd1:    seg_of = 8'hF9;
            4'd2:    seg_of = 8'hA4;
            4'd3:    seg_of = 8'hB0;
            4'd4:    seg_of = 8'h99;
            4'd5:    seg_of = 8'h92;
            4'd6:    seg_of = 8'h82;
            4'd7:    seg_of = 8'hF8;
            4'd8:    seg_of = 8'h80;
            4'd9:    seg_of = 8'h90;
            default: seg_of = 8'hFF;
        endcase
    endfunction

    assign live       = {bit_7, bit_6, bit_5, bit_4, bit_3, bit_2, bit_1, bit_0};
    assign last_phase = (phase == PW'(SHIFT_DIV - 1));

    // Frame for the current digit; index 0 reads the live inputs since the snapshot is taken on the same edge
    always_comb begin
        src   = (idx == 3'd0) ? live : snap;
        digit = src[{idx, 2'b00} +: 4];
        seg   = seg_of(digit);
`ifdef LEADING_ZERO_BLANK_EN
        seg   = (idx != 3'd0 && (src >> {idx, 2'b00}) == 32'd0) ? 8'hFF : seg;
`endif
        frame_nx = {seg, ~(8'd1 << idx)};
    end

    // Next-state logic of the scan FSM
    always_comb begin
        state_nx = state;
        case (state)
            WAIT:    state_nx = (scan_cnt == '0) ? LOAD : WAIT;
            LOAD:    state_nx = SHIFT;
            SHIFT:   state_nx = (last_phase && bit_cnt == 4'd0) ? LATCH : SHIFT;
            LATCH:   state_nx = WAIT;
            default: state_nx = WAIT;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= WAIT;
        else      state <= state_nx;
    end

    // Scan timer, serial shifter and 74HC595 control pins; shcp is high in the second half of each bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            idx      <= 3'd0;
            phase    <= '0;
            bit_cnt  <= 4'd0;
            snap     <= 32'd0;
            frame    <= 16'd0;
            ds       <= 1'b0;
            shcp     <= 1'b0;
            stcp     <= 1'b0;
            oe_n     <= 1'b1;
        end else begin
            scan_cnt <= (scan_cnt == CW'(SCAN_CNT_MAX - 1)) ? '0 : scan_cnt + 1'b1;
            shcp     <= 1'b0;
            stcp     <= 1'b0;
            case (state)
                LOAD: begin
                    if (idx == 3'd0) snap <= live;
                    frame   <= frame_nx;
                    ds      <= frame_nx[15];
                    phase   <= '0;
                    bit_cnt <= 4'd15;
                end
                SHIFT: begin
                    phase <= last_phase ? '0 : phase + 1'b1;
                    shcp  <= !last_phase && (int'(phase) + 1 >= SHIFT_DIV / 2);
                    if (last_phase) bit_cnt <= bit_cnt - 4'd1;
                    if (last_phase && bit_cnt == 4'd0) begin
                        stcp <= 1'b1;
                        oe_n <= 1'b0;
                    end else if (last_phase) begin
                        ds <= frame[bit_cnt - 4'd1];
                    end
                end
                LATCH: idx <= idx + 3'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seg_scan_hc595.sv
// tb_seg_scan_hc595: scoreboard bench; expected latched frames are queued by the stimulus and checked by a monitor decoding the serial pins.
module tb_seg_scan_hc595;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] b [8];
    logic       ds, shcp, stcp, oe_n;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] q[$];

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] Z = 8'hFF;
`else
    localparam logic [7:0] Z = 8'hC0;
`endif

    seg_scan_hc595 #(.SCAN_CNT_MAX(100), .SHIFT_DIV(4)) dut (
        .clk(clk), .rst(rst),
        .bit_0(b[0]), .bit_1(b[1]), .bit_2(b[2]), .bit_3(b[3]),
        .bit_4(b[4]), .bit_5(b[5]), .bit_6(b[6]), .bit_7(b[7]),
        .ds(ds), .shcp(shcp), .stcp(stcp), .oe_n(oe_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [3:0] v7, v6, v5, v4, v3, v2, v1, v0);
        b[7] = v7; b[6] = v6; b[5] = v5; b[4] = v4;
        b[3] = v3; b[2] = v2; b[1] = v1; b[0] = v0;
    endtask

    task automatic push_scan(input logic [7:0] s0, s1, s2, s3, s4, s5, s6, s7);
        q.push_back({s0, 8'hFE}); q.push_back({s1, 8'hFD});
        q.push_back({s2, 8'hFB}); q.push_back({s3, 8'hF7});
        q.push_back({s4, 8'hEF}); q.push_back({s5, 8'hDF});
        q.push_back({s6, 8'hBF}); q.push_back({s7, 8'h7F});
    endtask

    task automatic wait_size(input int n);
        int t = 0;
        while (q.size() != n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("queue_level", q.size(), n);
    endtask

    // Monitor: rebuild the shifted frame from ds on shcp rising edges and check it on each stcp pulse
    int          cyc = 0, edges = 0, last_stcp = 0;
    logic [15:0] sh = '0;
    logic        prev_shcp = 0, prev_stcp = 0, prev_oe = 1, have_prev = 0, first = 1;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            edges = 0; sh = '0; have_prev = 0; first = 1;
            prev_shcp = 0; prev_stcp = 0; prev_oe = 1;
        end else begin
            if (shcp && !prev_shcp) begin
                sh = {sh[14:0], ds};
                edges++;
            end
            if (stcp && !prev_stcp) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_latch actual=%h required=none", sh);
                end else begin
                    chk("frame", sh, q.pop_front());
                end
                chk("shcp_edges", edges, 16);
                if (have_prev) chk("stcp_spacing", cyc - last_stcp, 100);
                if (first) chk("oe_n_fall", {prev_oe, oe_n}, 2'b10);
                have_prev = 1; first = 0; last_stcp = cyc; edges = 0;
            end
            prev_shcp = shcp; prev_stcp = stcp; prev_oe = oe_n;
        end
    end

    initial begin
        int t;
        set_in(8, 7, 6, 5, 4, 3, 2, 1);
        repeat (2) @(negedge clk);
        chk("rst_ds", ds, 0); chk("rst_shcp", shcp, 0);
        chk("rst_stcp", stcp, 0); chk("rst_oe_n", oe_n, 1);
        rst = 1'b1;
        push_scan(8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80);
        // inputs change in slot 3; the rest of this scan must keep the old digits
        wait_size(5);
        repeat (50) @(negedge clk);
        set_in(9, 9, 9, 9, 9, 9, 9, 9);
        push_scan(8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90);
        wait_size(7);
        set_in(0, 0, 0, 0, 0, 12, 0, 5);
        push_scan(8'h92, 8'hC0, 8'hFF, Z, Z, Z, Z, Z);
        wait_size(7);
        set_in(0, 0, 0, 0, 0, 3, 0, 5);
        push_scan(8'h92, 8'hC0, 8'hB0, Z, Z, Z, Z, Z);
        wait_size(0);
        // abort the next frame (index 0 -> 92FE) during bit 7 of its shift
        t = 0;
        while (edges != 8 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("reach_bit7", edges, 8);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("abort_ds", ds, 0); chk("abort_shcp", shcp, 0);
        chk("abort_stcp", stcp, 0); chk("abort_oe_n", oe_n, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        q.push_back(16'h92FE);
        wait_size(0);
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
